// File: rtl/scroll_tick_gen.sv
// ---------------------------------------------------------------------------
// scroll_tick_gen
//
// Paces the scrolling of a playfield. While running, a clock divider counts
// up to the current tick period. On each tick the block asks the external
// offset counter either to advance by one (offset_increase) or, when the
// offset already sits at the last position before the row edge, to clear
// (edge_go). Each level_up pulse shortens the period by STEP, down to
// MIN_PERIOD, across speed levels 0..7.
//
// Optional feature: define SCROLL_PAUSE_EN to add the pausen input and a
// PAUSE state. While paused, the divider and the speed level hold and no
// pulses are issued.
//
// Parameters
//   BASE_PERIOD  clocks per tick at speed level 0
//   STEP         period reduction per speed level
//   MIN_PERIOD   lower clamp on the tick period
//   OFFSET_MAX   last offset value before the row edge
//
// Ports
//   clock            in   system clock, rising edge
//   resetn           in   synchronous reset, active low
//   startn           in   start/restart button, active low (already synchronised)
//   game_over        in   level; stop scrolling
//   level_up         in   single-cycle pulse; raise the speed level
//   offset_in[5:0]   in   current offset from the offset counter
//   pausen           in   (SCROLL_PAUSE_EN only) pause request, active low level
//   offset_increase  out  single-cycle pulse; advance the offset by one
//   edge_go          out  single-cycle pulse; offset reached the row edge
//   running          out  high while in RUN
//   speed_level[2:0] out  current speed level
// ---------------------------------------------------------------------------
module scroll_tick_gen #(
  parameter int BASE_PERIOD = 833333,
  parameter int STEP        = 62500,
  parameter int MIN_PERIOD  = 208333,
  parameter int OFFSET_MAX  = 59
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       startn,
  input  logic       game_over,
  input  logic       level_up,
  input  logic [5:0] offset_in,
`ifdef SCROLL_PAUSE_EN
  input  logic       pausen,
`endif
  output logic       offset_increase,
  output logic       edge_go,
  output logic       running,
  output logic [2:0] speed_level
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
`ifdef SCROLL_PAUSE_EN
    HALT  = 2'd2,
    PAUSE = 2'd3
`else
    HALT  = 2'd2
`endif
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        startn_prev_reg;
  logic        start_edge;
  logic [19:0] div_cnt_reg;
  logic [2:0]  speed_level_reg;
  logic        offset_increase_reg;
  logic        edge_go_reg;

  logic [23:0] period_lut [8];
  logic [23:0] period;
  logic        period_end;
  logic        tick;
  logic        at_row_edge;
  logic        inc_next;
  logic        edge_next;

  // Period per speed level is a compile-time constant, so the table replaces
  // a runtime multiply. Computing in signed int lets a period that would go
  // negative clamp to MIN_PERIOD instead of wrapping.
  for (genvar gi = 0; gi < 8; gi++) begin : g_period
    localparam int RAW_PERIOD = BASE_PERIOD - gi * STEP;
    assign period_lut[gi] = 24'((RAW_PERIOD < MIN_PERIOD) ? MIN_PERIOD : RAW_PERIOD);
  end

  assign period = period_lut[speed_level_reg];

  // A period that shrinks below the running count fires immediately,
  // so this is a >= test rather than ==.
  assign period_end = ({4'd0, div_cnt_reg} >= (period - 24'd1));

  assign start_edge = startn_prev_reg & ~startn;

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_edge) state_next = RUN;
      end
      RUN: begin
        if (game_over) begin
          state_next = HALT;
`ifdef SCROLL_PAUSE_EN
        end else if (!pausen) begin
          state_next = PAUSE;
`endif
        end
      end
      HALT: begin
        if (start_edge) state_next = IDLE;
      end
`ifdef SCROLL_PAUSE_EN
      PAUSE: begin
        if (game_over) begin
          state_next = HALT;
        end else if (pausen) begin
          state_next = RUN;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output / pulse decode. game_over suppresses a tick landing in the same
  // cycle, so the transition to HALT never leaves a stray pulse behind.
  always_comb begin
    running     = (state_reg == RUN);
    tick        = running && period_end && !game_over;
    at_row_edge = (offset_in >= 6'(OFFSET_MAX));
    inc_next    = tick && !at_row_edge;
    edge_next   = tick && at_row_edge;
  end

  // Divider, speed level and registered pulses
  always_ff @(posedge clock) begin
    if (!resetn) begin
      startn_prev_reg     <= 1'b1;
      div_cnt_reg         <= 20'd0;
      speed_level_reg     <= 3'd0;
      offset_increase_reg <= 1'b0;
      edge_go_reg         <= 1'b0;
    end else begin
      startn_prev_reg     <= startn;
      offset_increase_reg <= inc_next;
      edge_go_reg         <= edge_next;
      if (state_reg == IDLE && start_edge) begin
        div_cnt_reg     <= 20'd0;
        speed_level_reg <= 3'd0;
      end else if (state_reg == RUN) begin
        if (period_end) begin
          div_cnt_reg <= 20'd0;
        end else begin
          div_cnt_reg <= div_cnt_reg + 20'd1;
        end
        // level_up reads the old period this cycle; the new one takes
        // effect from the next cycle because the table index is registered.
        if (level_up && speed_level_reg != 3'd7) begin
          speed_level_reg <= speed_level_reg + 3'd1;
        end
      end
    end
  end

  assign offset_increase = offset_increase_reg;
  assign edge_go         = edge_go_reg;
  assign speed_level     = speed_level_reg;

endmodule
